// File: rtl/pc_sequencer_if.sv
// Bus between the control FSM and the program-counter sequencer.
// The control side drives the mode strobes and reads back the PC and stack status.
interface pc_sequencer_if #(
  parameter int N     = 9,
  parameter int OW    = 5,
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH + 1);

  logic          E;
  logic          L;
  logic          B;
  logic          C;
  logic          R;
  logic [N-1:0]  D;
  logic [OW-1:0] OFF;
  logic          clr_err;
  logic [N-1:0]  Q;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          err;

  modport master (
    output E, L, B, C, R, D, OFF, clr_err,
    input  Q, level, full, empty, err
  );

  modport slave (
    input  E, L, B, C, R, D, OFF, clr_err,
    output Q, level, full, empty, err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter successor: increment, load, signed relative branch, and
// call/return through a LIFO return-address stack with a sticky error flag.
module pc_sequencer #(
  parameter int N     = 9,
  parameter int OW    = 5,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  pc_sequencer_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_BRANCH,
    OP_LOAD,
    OP_RET,
    OP_CALL
  } op_e;

  logic [N-1:0]  q_q, q_d;
  logic [LW-1:0] level_q, level_d;
  logic          err_q, err_d;
  logic [N-1:0]  stack_q [DEPTH];

  op_e           op;
  logic          full, empty, push, err_evt;
  logic [AW-1:0] push_idx, pop_idx;
  logic [N-1:0]  ret_addr;

  function automatic logic signed [N-1:0] sext_off(input logic signed [OW-1:0] off);
    return N'(off);
  endfunction

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign push_idx = AW'(level_q);
  assign pop_idx  = AW'(level_q - LW'(1));
  assign ret_addr = q_q + N'(1);

  // Only the highest-priority strobe acts; lower ones lose their error effects too.
  always_comb begin
    op = OP_HOLD;
    if (bus.C)      op = OP_CALL;
    else if (bus.R) op = OP_RET;
    else if (bus.L) op = OP_LOAD;
    else if (bus.B) op = OP_BRANCH;
    else if (bus.E) op = OP_INC;
  end

  always_comb begin
    q_d     = q_q;
    level_d = level_q;
    push    = 1'b0;
    err_evt = 1'b0;
    case (op)
      OP_CALL: begin
        q_d = bus.D;
        if (full) begin
          err_evt = 1'b1;
        end else begin
          push    = 1'b1;
          level_d = level_q + LW'(1);
        end
      end
      OP_RET: begin
        if (empty) begin
          err_evt = 1'b1;
        end else begin
          q_d     = stack_q[pop_idx];
          level_d = level_q - LW'(1);
        end
      end
      OP_LOAD:   q_d = bus.D;
      OP_BRANCH: q_d = q_q + sext_off(bus.OFF);
      OP_INC:    q_d = q_q + N'(1);
      default:   ;
    endcase

    // A new error outranks a simultaneous clear.
    err_d = err_q;
    if (bus.clr_err) err_d = 1'b0;
    if (err_evt)     err_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q     <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      level_q <= level_d;
      err_q   <= err_d;
    end
  end

  // Return-address storage carries no reset; entries above level are never read.
  always_ff @(posedge clock) begin
    if (push) stack_q[push_idx] <= ret_addr;
  end

  assign bus.Q     = q_q;
  assign bus.level = level_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random strobes, checked
// against a queue-based reference model of the program counter and return stack.
module tb_pc_sequencer;
  localparam int N     = 9;
  localparam int OW    = 5;
  localparam int DEPTH = 4;
  localparam int MOD   = 1 << N;

  logic clock;
  logic reset;

  pc_sequencer_if #(.N(N), .OW(OW), .DEPTH(DEPTH)) bus_if ();

  pc_sequencer #(.N(N), .OW(OW), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // reference model
  int m_pc;
  int m_stk[$];
  bit m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit r, input bit l, input bit b, input bit e,
                            input int d, input int off, input bit clr);
    bit evt;
    int soff;
    evt = 1'b0;
    soff = (off >= (1 << (OW - 1))) ? off - (1 << OW) : off;
    if (c) begin
      if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % MOD);
      else evt = 1'b1;
      m_pc = d;
    end else if (r) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else evt = 1'b1;
    end else if (l) begin
      m_pc = d;
    end else if (b) begin
      m_pc = (m_pc + soff + MOD) % MOD;
    end else if (e) begin
      m_pc = (m_pc + 1) % MOD;
    end
    if (evt)      m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, ".Q"},     32'(bus_if.Q),     32'(m_pc));
    check_eq({tag, ".level"}, 32'(bus_if.level), 32'(m_stk.size()));
    check_eq({tag, ".full"},  32'(bus_if.full),  32'(m_stk.size() == DEPTH));
    check_eq({tag, ".empty"}, 32'(bus_if.empty), 32'(m_stk.size() == 0));
    check_eq({tag, ".err"},   32'(bus_if.err),   32'(m_err));
  endtask

  task automatic cyc(input string tag, input bit c, input bit r, input bit l, input bit b,
                     input bit e, input int d, input int off, input bit clr);
    bus_if.C       = c;
    bus_if.R       = r;
    bus_if.L       = l;
    bus_if.B       = b;
    bus_if.E       = e;
    bus_if.D       = N'(d);
    bus_if.OFF     = OW'(off);
    bus_if.clr_err = clr;
    model_step(c, r, l, b, e, d, off, clr);
    @(posedge clock);
    #1;
    check_model(tag);
    bus_if.C = 0; bus_if.R = 0; bus_if.L = 0; bus_if.B = 0; bus_if.E = 0;
    bus_if.clr_err = 0;
  endtask

  // Reset asserted between edges must clear state before the next edge.
  task automatic apply_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    bus_if.C = 0; bus_if.R = 0; bus_if.L = 0; bus_if.B = 0; bus_if.E = 0;
    bus_if.D = '0; bus_if.OFF = '0; bus_if.clr_err = 0;
    model_reset();
    #2;
    check_model("por");
    @(negedge clock);
    reset = 1'b1;

    // 1: dirty all state, then reset mid-cycle, then increment
    cyc("t1_und",  0, 1, 0, 0, 0, 0, 0, 0);
    cyc("t1_call", 1, 0, 0, 0, 0, 'h055, 0, 0);
    check_eq("t1_q055", 32'(bus_if.Q), 32'h055);
    apply_reset("t1_rst");
    cyc("t1_e1", 0, 0, 0, 0, 1, 0, 0, 0);
    check_eq("t1_q1", 32'(bus_if.Q), 1);
    cyc("t1_e2", 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("t1_e3", 0, 0, 0, 0, 1, 0, 0, 0);
    check_eq("t1_q3", 32'(bus_if.Q), 3);

    // 2: wrap and branch
    cyc("t2_ld",   0, 0, 1, 0, 0, 'h1FF, 0, 0);
    cyc("t2_wrap", 0, 0, 0, 0, 1, 0, 0, 0);
    check_eq("t2_q000", 32'(bus_if.Q), 0);
    cyc("t2_ld2",  0, 0, 1, 0, 0, 'h010, 0, 0);
    cyc("t2_bneg", 0, 0, 0, 1, 0, 0, 'b11100, 0);
    check_eq("t2_q00c", 32'(bus_if.Q), 'h00C);
    cyc("t2_ld3",  0, 0, 1, 0, 0, 'h1FA, 0, 0);
    cyc("t2_bpos", 0, 0, 0, 1, 0, 0, 'b01111, 0);
    check_eq("t2_q009", 32'(bus_if.Q), 'h009);

    // 3: nested call/return
    cyc("t3_ld", 0, 0, 1, 0, 0, 'h020, 0, 0);
    cyc("t3_c1", 1, 0, 0, 0, 0, 'h100, 0, 0);
    check_eq("t3_lvl1", 32'(bus_if.level), 1);
    cyc("t3_c2", 1, 0, 0, 0, 0, 'h180, 0, 0);
    check_eq("t3_lvl2", 32'(bus_if.level), 2);
    cyc("t3_r1", 0, 1, 0, 0, 0, 0, 0, 0);
    check_eq("t3_q101", 32'(bus_if.Q), 'h101);
    cyc("t3_r2", 0, 1, 0, 0, 0, 0, 0, 0);
    check_eq("t3_q021", 32'(bus_if.Q), 'h021);
    check_eq("t3_empty", 32'(bus_if.empty), 1);
    check_eq("t3_err", 32'(bus_if.err), 0);

    // 4: overflow, then LIFO drain
    apply_reset("t4_rst");
    for (int i = 1; i <= 4; i++) cyc("t4_call", 1, 0, 0, 0, 0, i * 'h10, 0, 0);
    check_eq("t4_full", 32'(bus_if.full), 1);
    cyc("t4_ovf", 1, 0, 0, 0, 0, 'h0AA, 0, 0);
    check_eq("t4_q0aa", 32'(bus_if.Q), 'h0AA);
    check_eq("t4_lvl4", 32'(bus_if.level), 4);
    check_eq("t4_err", 32'(bus_if.err), 1);
    for (int i = 3; i >= 0; i--) begin
      cyc("t4_ret", 0, 1, 0, 0, 0, 0, 0, 0);
      check_eq("t4_lifo", 32'(bus_if.Q), 32'(i * 'h10 + 1));
    end

    // 5: underflow and clear
    cyc("t5_clr0", 0, 0, 0, 0, 0, 0, 0, 1);
    cyc("t5_und",  0, 1, 0, 0, 0, 0, 0, 0);
    check_eq("t5_qhold", 32'(bus_if.Q), 'h001);
    check_eq("t5_err1", 32'(bus_if.err), 1);
    cyc("t5_clr",  0, 0, 0, 0, 0, 0, 0, 1);
    check_eq("t5_err0", 32'(bus_if.err), 0);
    cyc("t5_both", 0, 1, 0, 0, 0, 0, 0, 1);
    check_eq("t5_setwins", 32'(bus_if.err), 1);

    // 6: priority
    apply_reset("t6_rst");
    cyc("t6_ld",  0, 0, 1, 0, 0, 'h010, 0, 0);
    cyc("t6_all", 1, 1, 1, 0, 1, 'h033, 0, 0);
    check_eq("t6_q033", 32'(bus_if.Q), 'h033);
    check_eq("t6_lvl", 32'(bus_if.level), 1);
    cyc("t6_lbe", 0, 0, 1, 1, 1, 'h040, 3, 0);
    check_eq("t6_q040", 32'(bus_if.Q), 'h040);
    cyc("t6_ret", 0, 1, 0, 0, 0, 0, 0, 0);
    check_eq("t6_tos", 32'(bus_if.Q), 'h011);

    // random strobes against the reference model
    for (int i = 0; i < 400; i++) begin
      cyc("rnd",
          $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 0,
          int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, (1 << OW) - 1)),
          $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
